fc_operand_sequencer: RTL and testbench

Sequencer that feeds the fully connected MAC core, one output neuron at a time, and collects its results. For each neuron it:
- pulses the core's clear (`o_run`);
- streams `NUM_IN` node/weight pairs from the node and weight buffers, with the neuron bias sent only on the first element;
- waits for the core's accumulated result and presents it downstream on a valid/ready port.

It sits between the on-chip node, weight and bias buffers and the MAC core, and owns all addressing and per-layer control for one FC layer.

---
 rtl/fc_pkg.sv | 37 +++
 rtl/fc_operand_sequencer_addr_gen.sv | 70 +++++++
 rtl/fc_operand_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fc_operand_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg
// Shared definitions for the fully connected operand sequencer:
//   - sequencer state encoding
//   - default layer geometry and data width
//   - helpers deriving address widths and the accumulator result width
package fc_pkg;

    localparam int DEF_IN_DATA_WITDH = 16;
    localparam int DEF_NUM_IN        = 64;
    localparam int DEF_NUM_OUT       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } fc_state_t;

    // Address width for a buffer of 'depth' entries; a single-entry buffer
    // still gets a one-bit address so no port collapses to zero width.
    function automatic int fc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The core accumulates into a word four times the operand width.
    function automatic int fc_res_w(input int data_w);
        return 4 * data_w;
    endfunction

    localparam int DEF_RES_W       = fc_res_w(DEF_IN_DATA_WITDH);
    localparam int DEF_NODE_ADDR_W = fc_addr_w(DEF_NUM_IN);
    localparam int DEF_WEGT_ADDR_W = fc_addr_w(DEF_NUM_IN * DEF_NUM_OUT);
    localparam int DEF_BIAS_ADDR_W = fc_addr_w(DEF_NUM_OUT);

endpackage

// File: rtl/fc_operand_sequencer_addr_gen.sv
// fc_addr_gen
// Neuron (n) and element (k) counters with buffer address generation.
// The weight address is row-major (n*NUM_IN + k); a running row base is
// advanced by NUM_IN per neuron so no multiplier is needed.
// Ports:
//   clk, reset        clock, async active-high reset
//   clr_n / inc_n     restart at neuron 0 / advance to next neuron
//   clr_k / inc_k     restart at element 0 / advance element (wraps after last)
//   node_addr         k
//   wegt_addr         n*NUM_IN + k
//   bias_addr         n
//   k_last, n_last    terminal-count flags
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int NUM_OUT = DEF_NUM_OUT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clr_n,
    input  logic                                  inc_n,
    input  logic                                  clr_k,
    input  logic                                  inc_k,
    output logic [fc_addr_w(NUM_IN)-1:0]          node_addr,
    output logic [fc_addr_w(NUM_IN*NUM_OUT)-1:0]  wegt_addr,
    output logic [fc_addr_w(NUM_OUT)-1:0]         bias_addr,
    output logic                                  k_last,
    output logic                                  n_last
);

    localparam int KW = fc_addr_w(NUM_IN);
    localparam int NW = fc_addr_w(NUM_OUT);
    localparam int WW = fc_addr_w(NUM_IN * NUM_OUT);

    logic [KW-1:0] k_cnt;
    logic [NW-1:0] n_cnt;
    logic [WW-1:0] row_base;

    assign k_last = (k_cnt == KW'(NUM_IN - 1));
    assign n_last = (n_cnt == NW'(NUM_OUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_cnt <= '0;
        end else if (clr_k) begin
            k_cnt <= '0;
        end else if (inc_k) begin
            k_cnt <= k_last ? '0 : k_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_cnt    <= '0;
            row_base <= '0;
        end else if (clr_n) begin
            n_cnt    <= '0;
            row_base <= '0;
        end else if (inc_n) begin
            n_cnt    <= n_cnt + 1'b1;
            row_base <= row_base + WW'(NUM_IN);
        end
    end

    assign node_addr = k_cnt;
    assign bias_addr = n_cnt;
    assign wegt_addr = row_base + WW'(k_cnt);

endmodule

// File: rtl/fc_operand_sequencer.sv
// fc_operand_sequencer
// Feeds the FC MAC core one output neuron at a time: clears the core,
// streams NUM_IN node/weight pairs (bias on the first element only), waits
// for NUM_IN core valids and presents the accumulator on a valid/ready port.
// Ports:
//   clk, reset                       clock, async active-high reset
//   i_start / o_busy / o_done        layer control and status
//   o_node_addr, o_wegt_addr,
//   o_bias_addr, o_mem_rd            buffer read side (1-cycle latency)
//   i_node_data, i_wegt_data,
//   i_bias_data                      buffer read data
//   o_run, o_valid, o_node,
//   o_wegt, o_bias                   core operand side
//   i_core_valid, i_core_result      core result side
//   o_res_valid, o_res_data,
//   o_res_idx, i_res_ready           downstream result handshake
module fc_operand_sequencer
    import fc_pkg::*;
#(
    parameter int IN_DATA_WITDH = DEF_IN_DATA_WITDH,
    parameter int NUM_IN        = DEF_NUM_IN,
    parameter int NUM_OUT       = DEF_NUM_OUT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_start,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [fc_addr_w(NUM_IN)-1:0]          o_node_addr,
    output logic [fc_addr_w(NUM_IN*NUM_OUT)-1:0]  o_wegt_addr,
    output logic [fc_addr_w(NUM_OUT)-1:0]         o_bias_addr,
    output logic                                  o_mem_rd,
    input  logic [IN_DATA_WITDH-1:0]              i_node_data,
    input  logic [IN_DATA_WITDH-1:0]              i_wegt_data,
    input  logic [IN_DATA_WITDH-1:0]              i_bias_data,
    output logic                                  o_run,
    output logic                                  o_valid,
    output logic [IN_DATA_WITDH-1:0]              o_node,
    output logic [IN_DATA_WITDH-1:0]              o_wegt,
    output logic [IN_DATA_WITDH-1:0]              o_bias,
    input  logic                                  i_core_valid,
    input  logic [fc_res_w(IN_DATA_WITDH)-1:0]    i_core_result,
    output logic                                  o_res_valid,
    output logic [fc_res_w(IN_DATA_WITDH)-1:0]    o_res_data,
    output logic [fc_addr_w(NUM_OUT)-1:0]         o_res_idx,
    input  logic                                  i_res_ready
);

    localparam int RES_W = fc_res_w(IN_DATA_WITDH);
    localparam int NW    = fc_addr_w(NUM_OUT);
    // Return counter must reach NUM_IN, hence the +1 depth.
    localparam int RW    = fc_addr_w(NUM_IN + 1);

    fc_state_t     state, state_nxt;
    logic          clr_n, inc_n, clr_k, inc_k;
    logic          k_last, n_last;
    logic          capture;
    logic          valid_q, first_q;
    logic [RW-1:0] ret_cnt;
    logic          ret_last;

    fc_addr_gen #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clr_n     (clr_n),
        .inc_n     (inc_n),
        .clr_k     (clr_k),
        .inc_k     (inc_k),
        .node_addr (o_node_addr),
        .wegt_addr (o_wegt_addr),
        .bias_addr (o_bias_addr),
        .k_last    (k_last),
        .n_last    (n_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_n     = 1'b0;
        inc_n     = 1'b0;
        clr_k     = 1'b0;
        inc_k     = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    clr_n     = 1'b1;
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_k     = 1'b1;
                state_nxt = ST_FEED;
            end
            ST_FEED: begin
                inc_k = 1'b1;
                if (k_last) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_core_valid && ret_last) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (i_res_ready) begin
                    if (n_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        inc_n     = 1'b1;
                        state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy      = (state != ST_IDLE);
    assign o_done      = (state == ST_DONE);
    assign o_run       = (state == ST_CLEAR);
    assign o_mem_rd    = (state == ST_FEED);
    assign o_res_valid = (state == ST_OUT);

    // Read data arrives one cycle after the strobe, so the strobe delayed by
    // one cycle marks the operands as valid. The first-element flag travels
    // alongside it so the bias reaches the core exactly once per neuron.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            valid_q <= o_mem_rd;
            first_q <= o_mem_rd && (o_node_addr == '0);
        end
    end

    assign o_valid = valid_q;
    assign o_node  = valid_q ? i_node_data : '0;
    assign o_wegt  = valid_q ? i_wegt_data : '0;
    assign o_bias  = (valid_q && first_q) ? i_bias_data : '0;

    // Core valids start arriving while still feeding, so the counter runs in
    // every state and is only rearmed by CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            ret_cnt <= '0;
        end else if (i_core_valid) begin
            ret_cnt <= ret_cnt + 1'b1;
        end
    end

    assign ret_last = (ret_cnt == RW'(NUM_IN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_res_data <= '0;
            o_res_idx  <= '0;
        end else if (capture) begin
            o_res_data <= RES_W'(i_core_result);
            o_res_idx  <= NW'(o_bias_addr);
        end
    end

endmodule

// File: tb/tb_fc_operand_sequencer.sv
module tb_fc_operand_sequencer;

    localparam int W    = 16;
    localparam int NI   = 4;
    localparam int NO   = 2;
    localparam int RW   = 4 * W;

    logic          clk;
    logic          reset;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_node_addr;
    logic [2:0]    o_wegt_addr;
    logic [0:0]    o_bias_addr;
    logic          o_mem_rd;
    logic [W-1:0]  i_node_data, i_wegt_data, i_bias_data;
    logic          o_run, o_valid;
    logic [W-1:0]  o_node, o_wegt, o_bias;
    logic          i_core_valid;
    logic [RW-1:0] i_core_result;
    logic          o_res_valid;
    logic [RW-1:0] o_res_data;
    logic [0:0]    o_res_idx;
    logic          i_res_ready;

    fc_operand_sequencer #(
        .IN_DATA_WITDH (W),
        .NUM_IN        (NI),
        .NUM_OUT       (NO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_node_addr   (o_node_addr),
        .o_wegt_addr   (o_wegt_addr),
        .o_bias_addr   (o_bias_addr),
        .o_mem_rd      (o_mem_rd),
        .i_node_data   (i_node_data),
        .i_wegt_data   (i_wegt_data),
        .i_bias_data   (i_bias_data),
        .o_run         (o_run),
        .o_valid       (o_valid),
        .o_node        (o_node),
        .o_wegt        (o_wegt),
        .o_bias        (o_bias),
        .i_core_valid  (i_core_valid),
        .i_core_result (i_core_result),
        .o_res_valid   (o_res_valid),
        .o_res_data    (o_res_data),
        .o_res_idx     (o_res_idx),
        .i_res_ready   (i_res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer contents: nodes [1,2,3,4], weight rows [1,1,1,1] and [2,0,0,1],
    // biases 10 and 5.
    logic [W-1:0] mem_node [NI];
    logic [W-1:0] mem_wegt [NI*NO];
    logic [W-1:0] mem_bias [NO];

    initial begin
        mem_node = '{16'd1, 16'd2, 16'd3, 16'd4};
        mem_wegt = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd1};
        mem_bias = '{16'd10, 16'd5};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            i_node_data <= '0;
            i_wegt_data <= '0;
            i_bias_data <= '0;
        end else if (o_mem_rd) begin
            i_node_data <= mem_node[o_node_addr];
            i_wegt_data <= mem_wegt[o_wegt_addr];
            i_bias_data <= mem_bias[o_bias_addr];
        end
    end

    // MAC core: clear on run, accumulate node*wegt+bias on each valid,
    // report valid one cycle later.
    logic [RW-1:0] acc;
    logic          cv;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cv  <= 1'b0;
        end else begin
            cv <= o_valid;
            if (o_run) acc <= '0;
            else if (o_valid) acc <= acc + RW'(o_node) * RW'(o_wegt) + RW'(o_bias);
        end
    end
    assign i_core_result = acc;
    assign i_core_valid  = cv;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic start, ready;
        logic busy, run, rd;
        int   na, wa;
        logic v;
        int   node, wegt, bias;
        logic rv;
        int   rdata, ridx;
        logic done;
    } vec_t;

    function automatic vec_t mk(logic start, logic ready, logic busy, logic run, logic rd,
                                int na, int wa, logic v, int node, int wegt, int bias,
                                logic rv, int rdata, int ridx, logic done);
        vec_t t;
        t.start = start; t.ready = ready; t.busy = busy; t.run = run; t.rd = rd;
        t.na = na; t.wa = wa; t.v = v; t.node = node; t.wegt = wegt; t.bias = bias;
        t.rv = rv; t.rdata = rdata; t.ridx = ridx; t.done = done;
        return t;
    endfunction

    vec_t tbl [19];

    int           res_i [4];
    logic [63:0]  res_d [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (o_res_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Runs 'budget' cycles from posedge+1 with ready high, start on cycle 0
    // and optionally again on cycle pulse_at; records accepted results.
    task automatic collect(input int budget, input int pulse_at, output int nres, output int ndone);
        nres  = 0;
        ndone = 0;
        i_res_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            i_start = (c == 0) || (c == pulse_at);
            @(negedge clk);
            if (o_res_valid && i_res_ready) begin
                if (nres < 4) begin
                    res_d[nres] = o_res_data;
                    res_i[nres] = int'(o_res_idx);
                end
                nres++;
            end
            if (o_done) ndone++;
            step();
        end
        i_start = 1'b0;
    endtask

    task automatic check_layer(input string tag, input int nres, input int ndone);
        chk({tag, " nres"}, 64'(nres), 64'd2);
        chk({tag, " ndone"}, 64'(ndone), 64'd1);
        chk({tag, " res0"}, res_d[0], 64'd20);
        chk({tag, " idx0"}, 64'(res_i[0]), 64'd0);
        chk({tag, " res1"}, res_d[1], 64'd11);
        chk({tag, " idx1"}, 64'(res_i[1]), 64'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " busy"}, 64'(o_busy), 64'd0);
        chk({tag, " run"}, 64'(o_run), 64'd0);
        chk({tag, " rd"}, 64'(o_mem_rd), 64'd0);
        chk({tag, " valid"}, 64'(o_valid), 64'd0);
        chk({tag, " node"}, 64'(o_node), 64'd0);
        chk({tag, " bias"}, 64'(o_bias), 64'd0);
        chk({tag, " naddr"}, 64'(o_node_addr), 64'd0);
        chk({tag, " waddr"}, 64'(o_wegt_addr), 64'd0);
        chk({tag, " rvalid"}, 64'(o_res_valid), 64'd0);
        chk({tag, " done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nres, ndone;

        // start ready busy run rd na wa v node wegt bias rv rdata ridx done
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 10, 0, 0,  0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 1, 2, 2, 1, 2, 1, 0,  0, 0,  0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 1, 3, 3, 1, 3, 1, 0,  0, 0,  0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 4, 1, 0,  0, 0,  0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 20, 0, 0);
        tbl[9]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[10] = mk(0, 1, 1, 0, 1, 0, 4, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[11] = mk(0, 1, 1, 0, 1, 1, 5, 1, 1, 2, 5,  0, 0,  0, 0);
        tbl[12] = mk(0, 1, 1, 0, 1, 2, 6, 1, 2, 0, 0,  0, 0,  0, 0);
        tbl[13] = mk(0, 1, 1, 0, 1, 3, 7, 1, 3, 0, 0,  0, 0,  0, 0);
        tbl[14] = mk(0, 1, 1, 0, 0, 0, 0, 1, 4, 1, 0,  0, 0,  0, 0);
        tbl[15] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 11, 1, 0);
        tbl[17] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 1);
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0);

        reset = 1'b1;
        i_start = 1'b0;
        i_res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        chk("reset rdata", o_res_data, 64'd0);
        chk("reset ridx", 64'(o_res_idx), 64'd0);
        reset = 1'b0;
        step();

        // Full layer with ready high, checked cycle by cycle.
        for (int r = 0; r < 19; r++) begin
            i_start     = tbl[r].start;
            i_res_ready = tbl[r].ready;
            @(negedge clk);
            chk($sformatf("r%0d busy", r), 64'(o_busy), 64'(tbl[r].busy));
            chk($sformatf("r%0d run", r), 64'(o_run), 64'(tbl[r].run));
            chk($sformatf("r%0d rd", r), 64'(o_mem_rd), 64'(tbl[r].rd));
            chk($sformatf("r%0d valid", r), 64'(o_valid), 64'(tbl[r].v));
            chk($sformatf("r%0d node", r), 64'(o_node), 64'(tbl[r].node));
            chk($sformatf("r%0d wegt", r), 64'(o_wegt), 64'(tbl[r].wegt));
            chk($sformatf("r%0d bias", r), 64'(o_bias), 64'(tbl[r].bias));
            chk($sformatf("r%0d rvalid", r), 64'(o_res_valid), 64'(tbl[r].rv));
            chk($sformatf("r%0d done", r), 64'(o_done), 64'(tbl[r].done));
            if (tbl[r].rd) begin
                chk($sformatf("r%0d naddr", r), 64'(o_node_addr), 64'(tbl[r].na));
                chk($sformatf("r%0d waddr", r), 64'(o_wegt_addr), 64'(tbl[r].wa));
            end
            if (tbl[r].rv) begin
                chk($sformatf("r%0d rdata", r), o_res_data, 64'(tbl[r].rdata));
                chk($sformatf("r%0d ridx", r), 64'(o_res_idx), 64'(tbl[r].ridx));
            end
            step();
        end

        // Backpressure: ready low for 5 OUT cycles on neuron 0.
        i_res_ready = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_rv(60, ok);
        chk("bp rv seen n0", 64'(ok), 64'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp hold%0d rvalid", c), 64'(o_res_valid), 64'd1);
            chk($sformatf("bp hold%0d rdata", c), o_res_data, 64'd20);
            chk($sformatf("bp hold%0d ridx", c), 64'(o_res_idx), 64'd0);
            chk($sformatf("bp hold%0d run", c), 64'(o_run), 64'd0);
            step();
            @(negedge clk);
        end
        i_res_ready = 1'b1;
        chk("bp xfer rvalid", 64'(o_res_valid), 64'd1);
        chk("bp xfer rdata", o_res_data, 64'd20);
        step();
        @(negedge clk);
        chk("bp clear run", 64'(o_run), 64'd1);
        chk("bp clear rvalid", 64'(o_res_valid), 64'd0);
        step();
        wait_rv(60, ok);
        chk("bp rv seen n1", 64'(ok), 64'd1);
        chk("bp n1 rdata", o_res_data, 64'd11);
        chk("bp n1 ridx", 64'(o_res_idx), 64'd1);
        step();
        @(negedge clk);
        chk("bp done", 64'(o_done), 64'd1);
        step();
        @(negedge clk);
        chk("bp after done", 64'(o_done), 64'd0);
        chk("bp idle busy", 64'(o_busy), 64'd0);
        step();

        // Start pulsed during the second FEED cycle must be ignored.
        collect(40, 3, nres, ndone);
        check_layer("restart", nres, ndone);

        // Reset in the second FEED cycle aborts the layer.
        i_res_ready = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        chk("abort feed rd", 64'(o_mem_rd), 64'd1);
        chk("abort feed naddr", 64'(o_node_addr), 64'd1);
        reset = 1'b1;
        step();
        check_idle_zero("abort");
        reset = 1'b0;
        step();
        collect(30, -1, nres, ndone);
        check_layer("post_abort", nres, ndone);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
